// File: rtl/alu_seq_flags.sv
// Registered ARM data-processing ALU with NZCV flag register, multi-cycle
// shift-add multiplier and a valid/ready request handshake.
module alu_seq_flags #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flags_wr,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             res_we,
    output logic [3:0]       flags
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Adder carry is bit WIDTH of the widened sum.
    function automatic logic [WIDTH:0] add_c(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    function automatic logic add_v(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] acc_r, acc_nxt_s;
    logic [WIDTH-1:0] mcand_r, mcand_nxt_s;
    logic [WIDTH-1:0] mplier_r, mplier_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             mul_s_r, mul_s_nxt_s;
    logic [WIDTH-1:0] result_r, result_nxt_s;
    logic             res_we_r, res_we_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic [3:0]       flags_r, flags_nxt_s;
    logic             in_ready_r, in_ready_nxt_s;

    logic [WIDTH-1:0] add_x_s, add_y_s;
    logic             add_ci_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_arith_s, alu_we_s, alu_upd_s;
    logic [3:0]       alu_flags_s;
    logic [WIDTH-1:0] mul_step_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign res_we    = res_we_r;
    assign flags     = flags_r;

    // Adder operand selection; subtraction uses ~operand plus carry-in.
    always_comb begin
        add_x_s  = a;
        add_y_s  = b;
        add_ci_s = 1'b0;
        case (op[3:0])
            4'h2, 4'hA: begin add_y_s = ~b; add_ci_s = 1'b1;       end
            4'h3:       begin add_x_s = b; add_y_s = ~a; add_ci_s = 1'b1; end
            4'h5:       begin add_ci_s = flags_r[1];               end
            4'h6:       begin add_y_s = ~b; add_ci_s = flags_r[1]; end
            4'h7:       begin add_x_s = b; add_y_s = ~a; add_ci_s = flags_r[1]; end
            default:    begin add_ci_s = 1'b0;                     end
        endcase
        sum_s = add_c(add_x_s, add_y_s, add_ci_s);
    end

    // Single-cycle result, write-enable and flag computation.
    always_comb begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_arith_s = 1'b1;
        case (op[3:0])
            4'h0, 4'h8: begin alu_res_s = a & b;  alu_arith_s = 1'b0; end
            4'h1, 4'h9: begin alu_res_s = a ^ b;  alu_arith_s = 1'b0; end
            4'hC:       begin alu_res_s = a | b;  alu_arith_s = 1'b0; end
            4'hD:       begin alu_res_s = b;      alu_arith_s = 1'b0; end
            4'hE:       begin alu_res_s = a & ~b; alu_arith_s = 1'b0; end
            4'hF:       begin alu_res_s = ~b;     alu_arith_s = 1'b0; end
            default:    begin alu_res_s = sum_s[WIDTH-1:0]; alu_arith_s = 1'b1; end
        endcase
        // Compare/test ops write flags only, never the register file.
        alu_we_s  = (op[3:2] != 2'b10);
        alu_upd_s = (op[3:2] == 2'b10) || s;
        alu_flags_s[3] = alu_res_s[WIDTH-1];
        alu_flags_s[2] = (alu_res_s == {WIDTH{1'b0}});
        if (alu_arith_s) begin
            alu_flags_s[1] = sum_s[WIDTH];
            alu_flags_s[0] = add_v(add_x_s, add_y_s, sum_s[WIDTH-1:0]);
        end else begin
            alu_flags_s[1] = flags_r[1];
            alu_flags_s[0] = flags_r[0];
        end
    end

    // Next-state, datapath and output update logic.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        mcand_nxt_s     = mcand_r;
        mplier_nxt_s    = mplier_r;
        cnt_nxt_s       = cnt_r;
        mul_s_nxt_s     = mul_s_r;
        result_nxt_s    = result_r;
        res_we_nxt_s    = res_we_r;
        out_valid_nxt_s = 1'b0;
        flags_nxt_s     = flags_r;
        mul_step_s      = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op[4]) begin
                        if (op[3:0] == 4'h0) begin
                            state_nxt_s  = ST_MUL;
                            acc_nxt_s    = {WIDTH{1'b0}};
                            mcand_nxt_s  = a;
                            mplier_nxt_s = b;
                            cnt_nxt_s    = {CNT_W{1'b0}};
                            mul_s_nxt_s  = s;
                        end else begin
                            result_nxt_s    = a;
                            res_we_nxt_s    = 1'b0;
                            out_valid_nxt_s = 1'b1;
                        end
                    end else begin
                        result_nxt_s    = alu_res_s;
                        res_we_nxt_s    = alu_we_s;
                        out_valid_nxt_s = 1'b1;
                        if (alu_upd_s) begin
                            flags_nxt_s = alu_flags_s;
                        end else begin
                            flags_nxt_s = flags_r;
                        end
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_nxt_s    = mul_step_s;
                mcand_nxt_s  = {mcand_r[WIDTH-2:0], 1'b0};
                mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
                cnt_nxt_s    = cnt_r + 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s     = ST_IDLE;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    result_nxt_s    = mul_step_s;
                    res_we_nxt_s    = 1'b1;
                    out_valid_nxt_s = 1'b1;
                    if (mul_s_r) begin
                        flags_nxt_s = {mul_step_s[WIDTH-1],
                                       (mul_step_s == {WIDTH{1'b0}}),
                                       flags_r[1:0]};
                    end else begin
                        flags_nxt_s = flags_r;
                    end
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // A direct MSR-style write wins over any flag update from an op.
        if (flags_wr) begin
            flags_nxt_s = flags_in;
        end else begin
            flags_nxt_s = flags_nxt_s;
        end
        in_ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {WIDTH{1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mul_s_r     <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            res_we_r    <= 1'b0;
            out_valid_r <= 1'b0;
            flags_r     <= 4'b0000;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            mcand_r     <= mcand_nxt_s;
            mplier_r    <= mplier_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mul_s_r     <= mul_s_nxt_s;
            result_r    <= result_nxt_s;
            res_we_r    <= res_we_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            flags_r     <= flags_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_seq_flags.sv
// Scoreboard bench for alu_seq_flags: 32-bit and 8-bit instances driven with
// directed vectors; monitors compare each out_valid beat against a queue.
module tb_alu_seq_flags;

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic [3:0]  fl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q32[$];
    exp_t q8[$];

    logic        in_valid32, in_ready32, s32, flags_wr32, out_valid32, res_we32;
    logic [4:0]  op32;
    logic [31:0] a32, b32, result32;
    logic [3:0]  flags_in32, flags32;

    logic        in_valid8, in_ready8, s8, flags_wr8, out_valid8, res_we8;
    logic [4:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  flags_in8, flags8;

    alu_seq_flags #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .s(s32), .a(a32), .b(b32), .flags_wr(flags_wr32),
        .flags_in(flags_in32), .out_valid(out_valid32), .result(result32),
        .res_we(res_we32), .flags(flags32)
    );

    alu_seq_flags #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .s(s8), .a(a8), .b(b8), .flags_wr(flags_wr8),
        .flags_in(flags_in8), .out_valid(out_valid8), .result(result8),
        .res_we(res_we8), .flags(flags8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (rst_n && out_valid32) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out32 actual result=%h expected no output", result32);
            end else begin
                exp_t e;
                e = q32.pop_front();
                if (result32 !== e.res || res_we32 !== e.we || flags32 !== e.fl) begin
                    errors++;
                    $display("FAIL beat32 actual res=%h we=%b fl=%b expected res=%h we=%b fl=%b",
                             result32, res_we32, flags32, e.res, e.we, e.fl);
                end
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n && out_valid8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out8 actual result=%h expected no output", result8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                if ({24'h0, result8} !== e.res || res_we8 !== e.we || flags8 !== e.fl) begin
                    errors++;
                    $display("FAIL beat8 actual res=%h we=%b fl=%b expected res=%h we=%b fl=%b",
                             result8, res_we8, flags8, e.res[7:0], e.we, e.fl);
                end
            end
        end
    end

    task automatic issue32(input logic [4:0] o, input logic si, input logic [31:0] ai,
                           input logic [31:0] bi, input logic [31:0] er, input logic ew,
                           input logic [3:0] ef, input bit expect_out);
        exp_t e;
        e.res = er; e.we = ew; e.fl = ef;
        if (expect_out) q32.push_back(e);
        op32 = o; s32 = si; a32 = ai; b32 = bi; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0; flags_wr32 = 1'b0;
    endtask

    task automatic issue8(input logic [4:0] o, input logic si, input logic [7:0] ai,
                          input logic [7:0] bi, input logic [7:0] er, input logic ew,
                          input logic [3:0] ef);
        exp_t e;
        e.res = {24'h0, er}; e.we = ew; e.fl = ef;
        q8.push_back(e);
        op8 = o; s8 = si; a8 = ai; b8 = bi; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        in_valid32 = 1'b0; op32 = 5'h00; s32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
        flags_wr32 = 1'b0; flags_in32 = 4'b0000;
        in_valid8 = 1'b0; op8 = 5'h00; s8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
        flags_wr8 = 1'b0; flags_in8 = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready32}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid32}, 32'h0);
        chk("rst_result", result32, 32'h0);
        chk("rst_res_we", {31'h0, res_we32}, 32'h0);
        chk("rst_flags", {28'h0, flags32}, 32'h0);
        chk("rst_in_ready8", {31'h0, in_ready8}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops, back to back (ADC relies on C from CMP).
        issue32(5'h04, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 4'b1001, 1'b1);
        issue32(5'h0A, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 4'b0110, 1'b1);
        issue32(5'h05, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 4'b0110, 1'b1);
        issue32(5'h0C, 1'b1, 32'h80000000, 32'h00000001, 32'h80000001, 1'b1, 4'b1010, 1'b1);
        issue32(5'h02, 1'b1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 4'b1000, 1'b1);
        issue32(5'h09, 1'b0, 32'h000000A5, 32'h000000A5, 32'h00000000, 1'b0, 4'b0100, 1'b1);
        issue32(5'h0D, 1'b0, 32'h00000000, 32'h00001234, 32'h00001234, 1'b1, 4'b0100, 1'b1);
        issue32(5'h0F, 1'b1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 4'b1000, 1'b1);
        issue32(5'h03, 1'b1, 32'h00000001, 32'h00000010, 32'h0000000F, 1'b1, 4'b0010, 1'b1);
        issue32(5'h13, 1'b1, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 1'b0, 4'b0010, 1'b1);
        flags_wr32 = 1'b1; flags_in32 = 4'b1010;
        issue32(5'h04, 1'b1, 32'h00000001, 32'h00000002, 32'h00000003, 1'b1, 4'b1010, 1'b1);
        @(posedge clk); #1;
        flags_wr32 = 1'b1; flags_in32 = 4'b0011;
        @(posedge clk); #1;
        flags_wr32 = 1'b0;
        chk("msr_flags", {28'h0, flags32}, 32'h3);

        // MUL: busy for 32 cycles, ignored requests, C/V preserved.
        issue32(5'h10, 1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 4'b0111, 1'b1);
        op32 = 5'h04; s32 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("mul_busy_ready", {31'h0, in_ready32}, 32'h0);
            in_valid32 = ((i % 3) == 1);
            @(posedge clk); #1;
        end
        in_valid32 = 1'b0;
        chk("mul_done_valid", {31'h0, out_valid32}, 32'h1);
        chk("mul_done_ready", {31'h0, in_ready32}, 32'h1);
        @(posedge clk); #1;
        issue32(5'h10, 1'b1, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b1, 4'b1011, 1'b1);
        repeat (33) @(posedge clk);
        #1;

        // Reset in the middle of a MUL aborts it with no output.
        issue32(5'h10, 1'b0, 32'h00000003, 32'h00000005, 32'h0, 1'b0, 4'b0000, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'h0, in_ready32}, 32'h1);
        chk("abort_out_valid", {31'h0, out_valid32}, 32'h0);
        chk("abort_flags", {28'h0, flags32}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        issue32(5'h04, 1'b0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b1, 4'b0000, 1'b1);

        // 8-bit instance: boundary add, carry-chained SBC/RSC and short MUL.
        issue8(5'h04, 1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 4'b0111);
        issue8(5'h06, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0110);
        issue8(5'h07, 1'b1, 8'h05, 8'h03, 8'hFE, 1'b1, 4'b1000);
        issue8(5'h10, 1'b1, 8'h10, 8'h11, 8'h10, 1'b1, 4'b0000);
        repeat (12) @(posedge clk);
        #1;

        chk("q32_drained", q32.size(), 32'h0);
        chk("q8_drained", q8.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
